// File: rtl/dma_port_scheduler.sv
// dma_port_scheduler: queues DMA requests and issues them into whichever
// dual-port SRAM port is idle. Port B (accelerator) is preferred, then port A
// (CPU). Read data comes back in order, READ_LAT+1 cycles after issue.
// Optional build macro DMA_STARVE_GUARD_EN adds a FORCE state that steals
// port A from the CPU after STARVE_LIMIT blocked cycles.
module dma_port_scheduler #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH        = 4,
  parameter int READ_LAT     = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dma_req_valid,
  output logic                  dma_req_ready,
  input  logic                  dma_req_we,
  input  logic [ADDR_WIDTH-1:0] dma_req_addr,
  input  logic [DATA_WIDTH-1:0] dma_req_wdata,
  input  logic                  cpu_busy,
  input  logic                  acl_busy,
  output logic                  issue_a,
  output logic                  issue_b,
  output logic                  issue_we,
  output logic [ADDR_WIDTH-1:0] issue_addr,
  output logic [DATA_WIDTH-1:0] issue_wdata,
  input  logic [DATA_WIDTH-1:0] mem_q_a,
  input  logic [DATA_WIDTH-1:0] mem_q_b,
  output logic                  dma_rsp_valid,
  output logic [DATA_WIDTH-1:0] dma_rsp_rdata,
  output logic                  cpu_stall
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, WAIT, ISSUE, FORCE} state_t;

  state_t                state;
  logic [CNT_W-1:0]      wait_cnt;
  logic [CNT_W-1:0]      cnt_nxt;

  logic                  we_mem    [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem  [DEPTH];
  logic [DATA_WIDTH-1:0] wdata_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;
  logic [PTR_W:0]        count_nxt;

  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  blocked;
  logic                  force_now;

  logic [READ_LAT-1:0]   rd_vld_sr;
  logic [READ_LAT-1:0]   rd_port_sr;

  assign full          = (count == DEPTH_C);
  assign empty         = (count == '0);
  assign dma_req_ready = !full;
  assign push          = dma_req_valid && !full;
  assign pop           = issue_a || issue_b;
  // state is IDLE exactly when the FIFO is empty, so a non-idle cycle without
  // an issue is a cycle in which the head was blocked
  assign blocked       = (state != IDLE) && !pop;

  assign issue_we    = !empty && we_mem[rd_ptr];
  assign issue_addr  = empty ? '0 : addr_mem[rd_ptr];
  assign issue_wdata = empty ? '0 : wdata_mem[rd_ptr];

`ifdef DMA_STARVE_GUARD_EN
  assign force_now = (state == FORCE);
`else
  assign force_now = 1'b0;
`endif

  // Port selection for the head entry: B first, A second, forced A when starved
  always_comb begin
    issue_a   = 1'b0;
    issue_b   = 1'b0;
    cpu_stall = 1'b0;
    if (!empty) begin
      if (!acl_busy) begin
        issue_b = 1'b1;
      end else if (force_now) begin
        issue_a   = 1'b1;
        cpu_stall = 1'b1;
      end else if (!cpu_busy) begin
        issue_a = 1'b1;
      end
    end
  end

  // Next FIFO occupancy and next wait-counter value
  always_comb begin
    count_nxt = count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
    cnt_nxt   = wait_cnt;
    if (pop) begin
      cnt_nxt = '0;
    end else if (blocked && (wait_cnt != LIMIT_C)) begin
      cnt_nxt = wait_cnt + CNT_W'(1);
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
    end
  end

  // FIFO storage; contents are qualified by count so they need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      we_mem[wr_ptr]    <= dma_req_we;
      addr_mem[wr_ptr]  <= dma_req_addr;
      wdata_mem[wr_ptr] <= dma_req_wdata;
    end
  end

  // Scheduler FSM and starvation wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= cnt_nxt;
      if (count_nxt == '0) begin
        state <= IDLE;
      end else if (pop) begin
        state <= ISSUE;
`ifdef DMA_STARVE_GUARD_EN
      end else if (blocked && (cnt_nxt == LIMIT_C)) begin
        state <= FORCE;
`endif
      end else begin
        state <= WAIT;
      end
    end
  end

  // Read-tracking shift register: one slot per cycle of memory latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_sr  <= '0;
      rd_port_sr <= '0;
    end else begin
      rd_vld_sr  <= (rd_vld_sr << 1)  | READ_LAT'(pop && !issue_we);
      rd_port_sr <= (rd_port_sr << 1) | READ_LAT'(issue_b);
    end
  end

  // Response capture from the port recorded at issue time
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dma_rsp_valid <= 1'b0;
      dma_rsp_rdata <= '0;
    end else begin
      dma_rsp_valid <= rd_vld_sr[READ_LAT-1];
      if (rd_vld_sr[READ_LAT-1]) begin
        dma_rsp_rdata <= rd_port_sr[READ_LAT-1] ? mem_q_b : mem_q_a;
      end
    end
  end

endmodule

// File: tb/tb_dma_port_scheduler.sv
// Directed testbench for dma_port_scheduler (default parameters, READ_LAT=1).
// Inputs change 1 ns after the rising edge; outputs are checked 3 ns after it.
module tb_dma_port_scheduler;

  logic        clk;
  logic        rst;
  logic        dma_req_valid;
  logic        dma_req_ready;
  logic        dma_req_we;
  logic [31:0] dma_req_addr;
  logic [31:0] dma_req_wdata;
  logic        cpu_busy;
  logic        acl_busy;
  logic        issue_a;
  logic        issue_b;
  logic        issue_we;
  logic [31:0] issue_addr;
  logic [31:0] issue_wdata;
  logic [31:0] mem_q_a;
  logic [31:0] mem_q_b;
  logic        dma_rsp_valid;
  logic [31:0] dma_rsp_rdata;
  logic        cpu_stall;

  int checks = 0;
  int errors = 0;

  dma_port_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .dma_req_valid(dma_req_valid),
    .dma_req_ready(dma_req_ready),
    .dma_req_we   (dma_req_we),
    .dma_req_addr (dma_req_addr),
    .dma_req_wdata(dma_req_wdata),
    .cpu_busy     (cpu_busy),
    .acl_busy     (acl_busy),
    .issue_a      (issue_a),
    .issue_b      (issue_b),
    .issue_we     (issue_we),
    .issue_addr   (issue_addr),
    .issue_wdata  (issue_wdata),
    .mem_q_a      (mem_q_a),
    .mem_q_b      (mem_q_b),
    .dma_rsp_valid(dma_rsp_valid),
    .dma_rsp_rdata(dma_rsp_rdata),
    .cpu_stall    (cpu_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  task automatic push_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    dma_req_valid = 1'b1;
    dma_req_we    = we;
    dma_req_addr  = addr;
    dma_req_wdata = wdata;
    cyc();
    dma_req_valid = 1'b0;
    dma_req_we    = 1'b0;
    dma_req_addr  = '0;
    dma_req_wdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    dma_req_valid = 1'b0; dma_req_we = 1'b0; dma_req_addr = '0; dma_req_wdata = '0;
    cpu_busy = 1'b0; acl_busy = 1'b0; mem_q_a = '0; mem_q_b = '0;

    // reset state
    cyc(); cyc(); look();
    check("rst_ready", 32'(dma_req_ready), 32'd1);
    check("rst_issue_a", 32'(issue_a), 32'd0);
    check("rst_issue_b", 32'(issue_b), 32'd0);
    check("rst_rsp_valid", 32'(dma_rsp_valid), 32'd0);
    check("rst_rdata", dma_rsp_rdata, 32'h0);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_addr", issue_addr, 32'h0);
    cyc();
    rst = 1'b0;
    cyc();

    // read 0x100 through idle port B
    push_req(1'b0, 32'h100, 32'h0);
    look();
    check("t1_issue_b", 32'(issue_b), 32'd1);
    check("t1_issue_a", 32'(issue_a), 32'd0);
    check("t1_addr", issue_addr, 32'h100);
    check("t1_we", 32'(issue_we), 32'd0);
    cyc();
    mem_q_b = 32'hDEADBEEF;
    look();
    check("t1_rsp_early", 32'(dma_rsp_valid), 32'd0);
    check("t1_empty_issue", 32'(issue_b), 32'd0);
    cyc();
    mem_q_b = '0;
    look();
    check("t1_rsp_valid", 32'(dma_rsp_valid), 32'd1);
    check("t1_rdata", dma_rsp_rdata, 32'hDEADBEEF);
    cyc(); look();
    check("t1_rsp_pulse", 32'(dma_rsp_valid), 32'd0);

    // write through port A while accelerator holds B
    acl_busy = 1'b1; cpu_busy = 1'b0;
    push_req(1'b1, 32'h20, 32'h55);
    look();
    check("t2_issue_a", 32'(issue_a), 32'd1);
    check("t2_issue_b", 32'(issue_b), 32'd0);
    check("t2_we", 32'(issue_we), 32'd1);
    check("t2_addr", issue_addr, 32'h20);
    check("t2_wdata", issue_wdata, 32'h55);
    for (int i = 0; i < 3; i++) begin
      cyc();
      mem_q_a = 32'h1111_0000 + 32'(i);
      look();
      check("t2_no_rsp", 32'(dma_rsp_valid), 32'd0);
    end
    mem_q_a = '0;

    // fill FIFO with both ports busy, then drain through port B
    cyc();
    cpu_busy = 1'b1; acl_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dma_req_valid = 1'b1; dma_req_we = 1'b0; dma_req_addr = 32'h40 + 32'(4 * i);
      look();
      check("t3_ready_fill", 32'(dma_req_ready), 32'd1);
      cyc();
    end
    dma_req_addr = 32'h99;
    look();
    check("t3_ready_full", 32'(dma_req_ready), 32'd0);
    check("t3_blocked_b", 32'(issue_b), 32'd0);
    check("t3_blocked_a", 32'(issue_a), 32'd0);
    check("t3_head", issue_addr, 32'h40);
    cyc();
    dma_req_valid = 1'b0; dma_req_addr = '0;
    acl_busy = 1'b0;
    for (int k = 0; k < 7; k++) begin
      mem_q_b = (k >= 1) ? 32'hA000 + 32'(k - 1) : 32'h0;
      look();
      check("t3_issue_b", 32'(issue_b), (k < 4) ? 32'd1 : 32'd0);
      if (k < 4) check("t3_order", issue_addr, 32'h40 + 32'(4 * k));
      if (k == 0) check("t3_ready_k0", 32'(dma_req_ready), 32'd0);
      if (k == 1) check("t3_ready_k1", 32'(dma_req_ready), 32'd1);
      check("t3_rsp_valid", 32'(dma_rsp_valid), (k >= 2 && k < 6) ? 32'd1 : 32'd0);
      if (k >= 2 && k < 6) check("t3_rdata", dma_rsp_rdata, 32'hA000 + 32'(k - 2));
      cyc();
    end
    mem_q_b = '0;

    // reset with one read in flight and one queued
    cpu_busy = 1'b1; acl_busy = 1'b1;
    push_req(1'b0, 32'h80, 32'h0);
    push_req(1'b0, 32'h84, 32'h0);
    acl_busy = 1'b0;
    look();
    check("t4_issue_first", 32'(issue_b), 32'd1);
    cyc();
    acl_busy = 1'b1;
    rst = 1'b1;
    mem_q_b = 32'hBAD0BAD0;
    look();
    check("t4_rst_issue_a", 32'(issue_a), 32'd0);
    check("t4_rst_issue_b", 32'(issue_b), 32'd0);
    check("t4_rst_ready", 32'(dma_req_ready), 32'd1);
    check("t4_rst_addr", issue_addr, 32'h0);
    cyc();
    rst = 1'b0; acl_busy = 1'b0; cpu_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      look();
      check("t4_no_rsp", 32'(dma_rsp_valid), 32'd0);
      check("t4_no_issue", 32'(issue_a | issue_b), 32'd0);
      cyc();
    end
    mem_q_b = '0;

    // starvation behaviour with both ports busy
    cpu_busy = 1'b1; acl_busy = 1'b1;
    push_req(1'b0, 32'h200, 32'h0);
`ifdef DMA_STARVE_GUARD_EN
    for (int i = 0; i < 8; i++) begin
      look();
      check("t5_wait_issue", 32'(issue_a | issue_b), 32'd0);
      check("t5_wait_stall", 32'(cpu_stall), 32'd0);
      cyc();
    end
    look();
    check("t5_force_stall", 32'(cpu_stall), 32'd1);
    check("t5_force_a", 32'(issue_a), 32'd1);
    check("t5_force_b", 32'(issue_b), 32'd0);
    cyc();
    mem_q_a = 32'hCAFE0001;
    look();
    check("t5_stall_once", 32'(cpu_stall), 32'd0);
    check("t5_rsp_early", 32'(dma_rsp_valid), 32'd0);
    cyc();
    mem_q_a = '0;
    look();
    check("t5_rsp_valid", 32'(dma_rsp_valid), 32'd1);
    check("t5_rdata", dma_rsp_rdata, 32'hCAFE0001);
    cyc();
`else
    for (int i = 0; i < 20; i++) begin
      look();
      check("t6_no_issue", 32'(issue_a | issue_b), 32'd0);
      check("t6_no_stall", 32'(cpu_stall), 32'd0);
      cyc();
    end
    acl_busy = 1'b0;
    look();
    check("t6_late_issue_b", 32'(issue_b), 32'd1);
    check("t6_late_addr", issue_addr, 32'h200);
    cyc();
    mem_q_b = 32'h13572468;
    cyc();
    mem_q_b = '0;
    look();
    check("t6_rsp_valid", 32'(dma_rsp_valid), 32'd1);
    check("t6_rdata", dma_rsp_rdata, 32'h13572468);
    cyc();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_port_scheduler.md
Name: dma_port_scheduler

Overview:
Queues DMA memory requests and slips them into whichever dual-port SRAM port is idle in a given cycle. Port A is owned by the CPU and port B by the accelerator; DMA only gets leftover slots. Sits between the DMA engine and the memory controller's port muxes. Read data is returned in order, and an optional starvation guard can steal port A from the CPU.

Parameters:
DATA_WIDTH, 32, request/response data width
ADDR_WIDTH, 32, request address width
DEPTH, 4, request FIFO entries (power of 2, >=2)
READ_LAT, 1, cycles from issue to valid mem_q_a/mem_q_b (>=1)
STARVE_LIMIT, 8, wait cycles before forced issue (guard build only, >=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
dma_req_valid  in  1  DMA request present
dma_req_ready  out  1  FIFO can accept (= !full)
dma_req_we  in  1  1=write, 0=read
dma_req_addr  in  ADDR_WIDTH  request address
dma_req_wdata  in  DATA_WIDTH  write data
cpu_busy  in  1  CPU uses port A this cycle
acl_busy  in  1  accelerator uses port B this cycle
issue_a  out  1  DMA drives port A this cycle
issue_b  out  1  DMA drives port B this cycle
issue_we  out  1  head write enable
issue_addr  out  ADDR_WIDTH  head address
issue_wdata  out  DATA_WIDTH  head write data
mem_q_a  in  DATA_WIDTH  port A read data
mem_q_b  in  DATA_WIDTH  port B read data
dma_rsp_valid  out  1  read response valid, 1-cycle pulse
dma_rsp_rdata  out  DATA_WIDTH  read response data
cpu_stall  out  1  CPU must hold off port A (guard build only, else tied 0)

Behaviour:
- Reset values: FIFO empty; dma_req_ready=1; issue_a=issue_b=0; dma_rsp_valid=0; dma_rsp_rdata=0; cpu_stall=0; wait counter=0; FSM=IDLE.
- Reset mid-operation: flushes queued and in-flight requests; no response is produced for them.
- Push: on a clock edge with dma_req_valid && dma_req_ready. When full, ready=0; there is no same-cycle bypass of a pop.
- Issue is combinational from the FIFO head and cpu_busy/acl_busy. At most one issue per cycle. Pop happens on the edge of an issue cycle.
  - If head present and !acl_busy: issue_b=1.
  - Else if head present and !cpu_busy: issue_a=1.
  - Else: no issue.
- issue_we/issue_addr/issue_wdata equal the FIFO head and are 0 when empty.
- Read tracking: a READ_LAT-deep shift register records (read issued, port) per cycle.
  - For a read issued in cycle t, capture mem_q_a or mem_q_b (per recorded port) at the end of cycle t+READ_LAT.
  - dma_rsp_valid=1 with that data in cycle t+READ_LAT+1.
  - Writes generate no response.
  - Responses return in issue order, throughput 1 per cycle.
- FSM: IDLE (FIFO empty), WAIT (head blocked), ISSUE (head issued this cycle). Transitions:
  - IDLE->ISSUE/WAIT on first push.
  - WAIT->ISSUE when a port frees.
  - ISSUE->IDLE if FIFO becomes empty, else ISSUE/WAIT per port state.
- Wait counter, $clog2(STARVE_LIMIT+1) bits: increments each WAIT cycle, saturating at STARVE_LIMIT. Clears on any issue or reset.
- Simultaneous push into an empty FIFO and both ports free: the entry is issued the following cycle (port B).

Optional Feature:
DMA_STARVE_GUARD_EN
- Defined: FSM adds state FORCE, entered from WAIT when the wait counter reaches STARVE_LIMIT.
  - In FORCE, cpu_stall=1 combinationally and issue_a=1 regardless of cpu_busy; the head pops and the FSM leaves FORCE next cycle.
  - If acl_busy is 0 in FORCE: use issue_b instead and keep cpu_stall=0.
  - cpu_stall is never asserted for more than one consecutive cycle.
- Undefined: cpu_stall tied 0, no FORCE state; DMA may wait indefinitely.

Test Plan:
- Read 0x100 pushed, cpu_busy=acl_busy=0, READ_LAT=1, mem_q_b=0xDEADBEEF at t+1 -> issue_b=1 at t; dma_rsp_valid=1, rdata=0xDEADBEEF at t+2.
- acl_busy=1, cpu_busy=0; write 0x20 with wdata 0x55 -> issue_a=1, issue_we=1, issue_addr=0x20; no rsp_valid afterwards.
- Both busy; push 4 requests -> dma_req_ready=0 after 4th. Free port B -> 4 issues on consecutive cycles in push order; ready=1 after first pop.
- Both busy, 2 reads queued, rst pulsed high mid-queue -> issue_a/b=0, FIFO empty, no dma_rsp_valid after reset release.
- Guard build, STARVE_LIMIT=8, both busy, one read queued -> cpu_stall=1 and issue_a=1 in one cycle after 8 wait cycles; rsp follows READ_LAT+1 cycles later.
- Guard undefined, both busy 20 cycles -> no issue, cpu_stall=0 throughout.
